// File: rtl/adc_sample_packer.sv
// Packs pairs of ADC samples into 32-bit words and buffers them in a
// first-word-fall-through FIFO for the FX3 StreamIN writer.
module adc_sample_packer #(
    parameter int unsigned ADC_BITS = 12,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic                clk_100,
    input  logic                reset_,
    input  logic                enable,
    input  logic [ADC_BITS-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                rd_en,
    output logic [31:0]         data_out,
    output logic                data_avail,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                overflow,
    output logic [15:0]         drop_count,
    input  logic                clear_ovf
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;

    localparam logic [0:0] HALF_EMPTY = 1'b0;
    localparam logic [0:0] HALF_FULL  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [ADC_BITS-1:0] hold_q, hold_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_count_q, drop_count_d;
    logic [31:0]         mem_q [DEPTH];

    logic                push_c;
    logic                pop_c;
    logic                full_c;
    logic                wr_en_c;
    logic                drop_c;
    logic [31:0]         word_c;

    // Pack FSM, FIFO pointer/level bookkeeping and overflow accounting.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        word_c  = {16'(adc_data), 16'(hold_q)};
        full_c  = (level_q == LW'(DEPTH));
        pop_c   = enable && rd_en && (level_q != '0);
        push_c  = enable && adc_valid && (state_q == HALF_FULL);
        // A full FIFO still accepts the word when the same cycle frees a slot.
        wr_en_c = push_c && (!full_c || pop_c);
        drop_c  = push_c && full_c && !pop_c;

        if (enable && adc_valid) begin
            if (state_q == HALF_EMPTY) begin
                hold_d  = adc_data;
                state_d = HALF_FULL;
            end else begin
                state_d = HALF_EMPTY;
            end
        end

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end

        case ({wr_en_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (clear_ovf) begin
            overflow_d   = 1'b0;
            drop_count_d = 16'h0000;
        end
        // A drop coinciding with a clear restarts the count at one.
        if (drop_c) begin
            overflow_d = 1'b1;
            if (clear_ovf) begin
                drop_count_d = 16'h0001;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'h0001;
            end
        end

        if (!enable) begin
            state_d      = HALF_EMPTY;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = 16'h0000;
        end
    end

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            state_q      <= HALF_EMPTY;
            hold_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage array is not reset; contents are meaningless until written.
    always_ff @(posedge clk_100) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= word_c;
        end
    end

    assign data_out   = mem_q[rd_ptr_q];
    assign data_avail = (level_q != '0);
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_adc_sample_packer;

    localparam int unsigned ADC_BITS = 12;
    localparam int unsigned FIFO_AW  = 4;
    localparam int unsigned DEPTH    = 1 << FIFO_AW;

    logic                clk_100 = 1'b0;
    logic                reset_;
    logic                enable;
    logic [ADC_BITS-1:0] adc_data;
    logic                adc_valid;
    logic                rd_en;
    logic [31:0]         data_out;
    logic                data_avail;
    logic [FIFO_AW:0]    fifo_level;
    logic                overflow;
    logic [15:0]         drop_count;
    logic                clear_ovf;

    adc_sample_packer #(.ADC_BITS(ADC_BITS), .FIFO_AW(FIFO_AW)) dut (
        .clk_100    (clk_100),
        .reset_     (reset_),
        .enable     (enable),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_avail (data_avail),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clear_ovf  (clear_ovf)
    );

    always #5 clk_100 = ~clk_100;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: stored words, pending low sample, error counters.
    logic [31:0]         m_q[$];
    logic                m_half;
    logic [ADC_BITS-1:0] m_s0;
    logic                m_ovf;
    logic [15:0]         m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_half = 1'b0;
        m_s0   = '0;
        m_ovf  = 1'b0;
        m_cnt  = 16'h0000;
    endtask

    // One clock edge of the model, using the inputs presented for that edge.
    task automatic model_step();
        logic        have_word;
        logic [31:0] word;
        have_word = 1'b0;
        word      = '0;
        if (!enable) begin
            model_reset();
        end else begin
            if (adc_valid) begin
                if (m_half) begin
                    word      = {16'(adc_data), 16'(m_s0)};
                    have_word = 1'b1;
                    m_half    = 1'b0;
                end else begin
                    m_s0   = adc_data;
                    m_half = 1'b1;
                end
            end
            if (clear_ovf) begin
                m_ovf = 1'b0;
                m_cnt = 16'h0000;
            end
            if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
            if (have_word) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(word);
                end else begin
                    m_ovf = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
                end
            end
        end
    endtask

    task automatic compare();
        check("model_avail", 32'(data_avail), 32'(m_q.size() != 0));
        check("model_level", 32'(fifo_level), 32'(m_q.size()));
        check("model_ovf", 32'(overflow), 32'(m_ovf));
        check("model_drops", 32'(drop_count), 32'(m_cnt));
        if (m_q.size() > 0) check("model_head", data_out, m_q[0]);
    endtask

    task automatic cyc();
        @(posedge clk_100);
        model_step();
        @(negedge clk_100);
        compare();
    endtask

    task automatic feed(input logic [ADC_BITS-1:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        cyc();
        adc_valid = 1'b0;
    endtask

    initial begin
        reset_    = 1'b0;
        enable    = 1'b0;
        adc_data  = '0;
        adc_valid = 1'b0;
        rd_en     = 1'b0;
        clear_ovf = 1'b0;
        model_reset();
        #12;
        check("rst_avail", 32'(data_avail), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        @(negedge clk_100);
        reset_ = 1'b1;
        enable = 1'b1;

        // First pair becomes visible right after the second sample's edge.
        feed(12'h001);
        check("t1_avail_early", 32'(data_avail), 32'd0);
        feed(12'h002);
        check("t1_avail", 32'(data_avail), 32'd1);
        check("t1_level", 32'(fifo_level), 32'd1);
        check("t1_data", data_out, 32'h0002_0001);

        // Flush, then overfill: 20 words into a 16-deep FIFO.
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        for (int i = 0; i < 40; i++) feed(ADC_BITS'(i));
        check("t2_level", 32'(fifo_level), 32'd16);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_drops", 32'(drop_count), 32'd4);
        check("t2_data", data_out, 32'h0001_0000);

        // Full FIFO: pop in the same cycle a word completes.
        feed(12'h100);
        rd_en = 1'b1;
        feed(12'h101);
        rd_en = 1'b0;
        check("t3_level", 32'(fifo_level), 32'd16);
        check("t3_drops", 32'(drop_count), 32'd4);
        check("t3_data", data_out, 32'h0003_0002);
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) cyc();
        check("t3_wrapped", data_out, 32'h0101_0100);
        cyc();
        rd_en = 1'b0;
        check("t3_drained", 32'(data_avail), 32'd0);

        // Orphan sample discarded by a one-cycle flush.
        feed(12'h010);
        feed(12'h011);
        feed(12'h012);
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        feed(12'h0AA);
        feed(12'h0BB);
        check("t4_level", 32'(fifo_level), 32'd1);
        check("t4_data", data_out, 32'h00BB_00AA);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_drops", 32'(drop_count), 32'd0);

        // Pop requests against an empty FIFO, then a push-while-empty.
        rd_en = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        check("t5_empty", 32'(fifo_level), 32'd0);
        feed(12'h055);
        feed(12'h066);
        check("t5_avail", 32'(data_avail), 32'd1);
        check("t5_data", data_out, 32'h0066_0055);
        cyc();
        check("t5_popped", 32'(data_avail), 32'd0);
        rd_en = 1'b0;

        // Saturation and clear precedence.
        for (int i = 0; i < 34; i++) feed(ADC_BITS'(i + 12'h200));
        check("t6_first_drop", 32'(drop_count), 32'd1);
        #1 force dut.drop_count_q = 16'hFFFE;
        #1 release dut.drop_count_q;
        m_cnt = 16'hFFFE;
        cyc();
        check("t6_preset", 32'(drop_count), 32'h0000_FFFE);
        feed(12'h300);
        feed(12'h301);
        check("t6_max", 32'(drop_count), 32'h0000_FFFF);
        feed(12'h302);
        feed(12'h303);
        check("t6_sat", 32'(drop_count), 32'h0000_FFFF);
        check("t6_ovf", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        cyc();
        clear_ovf = 1'b0;
        check("t6_clr_ovf", 32'(overflow), 32'd0);
        check("t6_clr_drops", 32'(drop_count), 32'd0);
        feed(12'h304);
        clear_ovf = 1'b1;
        feed(12'h305);
        clear_ovf = 1'b0;
        check("t6_coinc_ovf", 32'(overflow), 32'd1);
        check("t6_coinc_drops", 32'(drop_count), 32'd1);
        check("t6_level", 32'(fifo_level), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
